instr_sequencer: RTL
====================

# instr_sequencer

Multi-cycle control sequencer for the 6-bit-opcode accumulator core. It steps each instruction through fetch, decode, an optional memory or long-ALU wait, and writeback. It handshakes with instruction memory, data memory and the multi-cycle ALU, and issues the 8-bit datapath control word as a one-cycle strobe. It sits between the memories and the datapath, replacing the free-running opcode-edge decoder with a clocked FSM.

## Interface
- `OPW`, 6: opcode width.
- `RCW`, 16: retired-instruction counter width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: level; leave IDLE and begin fetching.
- `halt` in 1: level; finish current instruction, then return to IDLE.
- `imem_req` out 1: instruction fetch request, held until ack.
- `imem_ack` in 1: instruction word valid this cycle.
- `opcode` in OPW: opcode from instruction memory, valid with `imem_ack`.
- `dmem_req` out 1: data access request (load/store), held until ack.
- `dmem_we` out 1: 1 = store; valid while `dmem_req`.
- `dmem_ack` in 1: data access complete.
- `alu_start` out 1: one-cycle pulse launching mul/div/mod.
- `alu_done` in 1: multi-cycle ALU result ready.
- `flags` in 4: {o,c,n,z} registered by datapath.
- `ir_load` out 1: pulse, latch instruction register.
- `ctrl_valid` out 1: pulse, `ctrl` applies this cycle.
- `ctrl` out 8: {next, br/oth, aluOp, lse, ldm, lacc, abs, spo}.
- `pc_inc` out 1: pulse, PC += 1.
- `pc_load` out 1: pulse, PC := branch/jump target.
- `illegal` out 1: sticky; undefined opcode trapped.
- `busy` out 1: state ≠ IDLE and ≠ TRAP.
- `retired` out RCW: instructions completed, wraps modulo 2^RCW.

## Operation
- States: IDLE, FETCH, DECODE, MEM, MULTI, WB, TRAP.
- IDLE → FETCH when `start` && !`halt`. If both are high, `halt` wins and the FSM stays in IDLE.
- FETCH: `imem_req`=1. When `imem_ack` is seen, pulse `ir_load`, capture `opcode` into IR, → DECODE.
- DECODE: one cycle; classify IR.
  - 0x04 load, 0x05 store → MEM.
  - 0x10–0x12 (mul/div/mod) → MULTI; `alu_start` pulses in the DECODE→MULTI transition cycle.
  - 0x00–0x03, 0x06–0x0F, 0x13–0x1A → WB.
  - 0x1B–0x3F → TRAP.
- MEM: `dmem_req`=1, `dmem_we`=(IR==0x05). On `dmem_ack` → WB.
- MULTI: wait for `alu_done` → WB. `alu_start` does not re-pulse.
- WB: `ctrl_valid`=1 and `ctrl`=decode(IR). Exactly one of `pc_inc`/`pc_load` is 1:
  - `pc_load` for 0x06–0x08.
  - `pc_load` for 0x00/01/02/03 when z/n/c/o is set, respectively, sampled in the WB cycle.
  - `pc_inc` otherwise.
  - `retired` += 1.
  - Next state: IDLE if `halt`, else FETCH.
- TRAP: `illegal`=1, all strobes 0. Only `rst` exits TRAP.
- `ctrl` is 0 whenever `ctrl_valid`=0. The value 8'hFF is never driven.

## Timing
- Reset (rst=0, async): state IDLE, IR=0, `retired`=0, `illegal`=0, and every other output 0.
- Minimum latency, with ack in the same cycle as req:
  - ALU/branch: 3 cycles (FETCH, DECODE, WB).
  - Load/store: 4 cycles.
  - mul/div/mod: 3 cycles + ALU latency.
- Req/ack: `imem_req`/`dmem_req` rise on state entry and stay high until the ack cycle inclusive, then drop the next cycle. An ack while req=0 is ignored.
- `halt` is checked only in IDLE and WB. Asserting it mid-instruction never aborts a memory or ALU handshake.
- `retired` wraps from 0xFFFF to 0 with no flag.
- Reset mid-handshake: req drops immediately (async). A later ack is ignored.

## Configuration
- `SEQ_MULTICYCLE_EN` defined: MULTI state, `alu_start` and `alu_done` are active as described above.
- Undefined: 0x10–0x12 go DECODE→WB like other ALU ops. `alu_start` is tied 0 and `alu_done` is ignored.

## Structure
- Package `cu_pkg` holds:
  - opcode localparams (BRZ…DEC);
  - the state enum;
  - ctrl bit-index constants;
  - the instruction-class enum (BRANCH, JUMP, MEM, ALU, MULTI, ILLEGAL).
- Sub-module `ctrl_decode` is combinational: IR → {class, ctrl[7:0]}. It holds the control-word table.
- `instr_sequencer` holds the FSM, IR, `retired` counter and sticky `illegal`.

## Test plan
- add (0x09), `imem_ack` same cycle:
  - `ir_load` at cycle 1;
  - WB at cycle 3 with `ctrl`=8'hA4, `pc_inc`=1;
  - `retired`=1.
- load (0x04), `dmem_ack` delayed 3 cycles:
  - `dmem_req` high for 3 cycles, `dmem_we`=0;
  - WB `ctrl`=8'hD8.
- brz (0x00):
  - flags.z=1 → `pc_load`=1, `pc_inc`=0;
  - repeat with z=0 → `pc_inc`=1.
- div (0x11) with `SEQ_MULTICYCLE_EN`, `alu_done` after 5 cycles:
  - one `alu_start` pulse;
  - WB 1 cycle after `alu_done`.
- Opcode 0x2A:
  - TRAP, `illegal`=1, `busy`=0, no further `imem_req`;
  - `rst` low clears everything.
- `halt` raised during MEM: store completes and retires, then IDLE. `start`+`halt` together in IDLE: stays IDLE.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the accumulator-core control unit: opcodes, FSM states,
// control-word bit positions and instruction classes.
package cu_pkg;

   localparam logic [5:0] OP_BRZ  = 6'h00;
   localparam logic [5:0] OP_BRN  = 6'h01;
   localparam logic [5:0] OP_BRC  = 6'h02;
   localparam logic [5:0] OP_BRO  = 6'h03;
   localparam logic [5:0] OP_LD   = 6'h04;
   localparam logic [5:0] OP_ST   = 6'h05;
   localparam logic [5:0] OP_JMP  = 6'h06;
   localparam logic [5:0] OP_CALL = 6'h07;
   localparam logic [5:0] OP_RET  = 6'h08;
   localparam logic [5:0] OP_ADD  = 6'h09;
   localparam logic [5:0] OP_SUB  = 6'h0A;
   localparam logic [5:0] OP_AND  = 6'h0B;
   localparam logic [5:0] OP_OR   = 6'h0C;
   localparam logic [5:0] OP_XOR  = 6'h0D;
   localparam logic [5:0] OP_NOT  = 6'h0E;
   localparam logic [5:0] OP_SHL  = 6'h0F;
   localparam logic [5:0] OP_MUL  = 6'h10;
   localparam logic [5:0] OP_DIV  = 6'h11;
   localparam logic [5:0] OP_MOD  = 6'h12;
   localparam logic [5:0] OP_SHR  = 6'h13;
   localparam logic [5:0] OP_ROL  = 6'h14;
   localparam logic [5:0] OP_ROR  = 6'h15;
   localparam logic [5:0] OP_NEG  = 6'h16;
   localparam logic [5:0] OP_CLR  = 6'h17;
   localparam logic [5:0] OP_CMP  = 6'h18;
   localparam logic [5:0] OP_INC  = 6'h19;
   localparam logic [5:0] OP_DEC  = 6'h1A;

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_DECODE, ST_MEM, ST_MULTI, ST_WB, ST_TRAP
   } state_t;

   // ctrl = {next, br/oth, aluOp, lse, ldm, lacc, abs, spo}
   localparam int CB_SPO   = 0;
   localparam int CB_ABS   = 1;
   localparam int CB_LACC  = 2;
   localparam int CB_LDM   = 3;
   localparam int CB_LSE   = 4;
   localparam int CB_ALUOP = 5;
   localparam int CB_BR    = 6;
   localparam int CB_NEXT  = 7;

   typedef enum logic [2:0] {
      IC_BRANCH, IC_JUMP, IC_MEM, IC_ALU, IC_MULTI, IC_ILLEGAL
   } iclass_t;

   function automatic logic [7:0] cw(input logic nxt, input logic br, input logic aluop,
                                     input logic lse, input logic ldm, input logic lacc,
                                     input logic absb, input logic spo);
      logic [7:0] w;
      w           = 8'h00;
      w[CB_NEXT]  = nxt;
      w[CB_BR]    = br;
      w[CB_ALUOP] = aluop;
      w[CB_LSE]   = lse;
      w[CB_LDM]   = ldm;
      w[CB_LACC]  = lacc;
      w[CB_ABS]   = absb;
      w[CB_SPO]   = spo;
      return w;
   endfunction

endpackage

// File: rtl/instr_sequencer_decode.sv
// Combinational instruction classifier and control-word table: IR -> {class, ctrl}.
// No state; the all-ones word is never produced for any opcode.
module ctrl_decode
   import cu_pkg::*;
#(
   parameter int OPW = 6
) (
   input  logic [OPW-1:0] ir,
   output iclass_t        icls,
   output logic [7:0]     ctrl
);

   always_comb begin
      icls = IC_ILLEGAL;
      ctrl = 8'h00;
      case (ir)
         OPW'(OP_BRZ), OPW'(OP_BRN),
         OPW'(OP_BRC), OPW'(OP_BRO): begin icls = IC_BRANCH; ctrl = cw(0,1,0,0,0,0,0,0); end
         OPW'(OP_LD):   begin icls = IC_MEM;   ctrl = cw(1,1,0,1,1,0,0,0); end
         OPW'(OP_ST):   begin icls = IC_MEM;   ctrl = cw(1,1,0,1,0,0,0,1); end
         OPW'(OP_JMP):  begin icls = IC_JUMP;  ctrl = cw(0,1,0,0,0,0,1,0); end
         OPW'(OP_CALL): begin icls = IC_JUMP;  ctrl = cw(0,1,0,0,0,0,1,1); end
         OPW'(OP_RET):  begin icls = IC_JUMP;  ctrl = cw(0,1,0,0,0,0,0,1); end
         OPW'(OP_ADD):  begin icls = IC_ALU;   ctrl = cw(1,0,1,0,0,1,0,0); end
         OPW'(OP_SUB):  begin icls = IC_ALU;   ctrl = cw(1,0,1,0,0,1,0,1); end
         OPW'(OP_AND):  begin icls = IC_ALU;   ctrl = cw(1,0,1,0,0,1,1,0); end
         OPW'(OP_OR):   begin icls = IC_ALU;   ctrl = cw(1,0,1,0,0,1,1,1); end
         OPW'(OP_XOR):  begin icls = IC_ALU;   ctrl = cw(1,0,1,1,0,1,0,0); end
         OPW'(OP_NOT):  begin icls = IC_ALU;   ctrl = cw(1,0,1,1,0,1,0,1); end
         OPW'(OP_SHL):  begin icls = IC_ALU;   ctrl = cw(1,0,1,1,0,1,1,0); end
         OPW'(OP_MUL):  begin icls = IC_MULTI; ctrl = cw(1,0,1,0,1,1,0,0); end
         OPW'(OP_DIV):  begin icls = IC_MULTI; ctrl = cw(1,0,1,0,1,1,0,1); end
         OPW'(OP_MOD):  begin icls = IC_MULTI; ctrl = cw(1,0,1,0,1,1,1,0); end
         OPW'(OP_SHR):  begin icls = IC_ALU;   ctrl = cw(1,0,1,1,0,1,1,1); end
         OPW'(OP_ROL):  begin icls = IC_ALU;   ctrl = cw(1,1,1,0,0,1,0,0); end
         OPW'(OP_ROR):  begin icls = IC_ALU;   ctrl = cw(1,1,1,0,0,1,0,1); end
         OPW'(OP_NEG):  begin icls = IC_ALU;   ctrl = cw(1,1,1,0,0,1,1,0); end
         OPW'(OP_CLR):  begin icls = IC_ALU;   ctrl = cw(1,0,0,0,0,1,0,0); end
         OPW'(OP_CMP):  begin icls = IC_ALU;   ctrl = cw(1,0,1,0,0,0,0,0); end
         OPW'(OP_INC):  begin icls = IC_ALU;   ctrl = cw(1,1,1,0,0,1,1,1); end
         OPW'(OP_DEC):  begin icls = IC_ALU;   ctrl = cw(1,1,1,1,0,1,0,0); end
         default:       begin icls = IC_ILLEGAL; ctrl = 8'h00; end
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/(mem|alu wait)/writeback sequencer; min 3 cycles per instruction,
// stalls on imem/dmem/alu acks. Define SEQ_MULTICYCLE_EN to route mul/div/mod through MULTI.
module instr_sequencer
   import cu_pkg::*;
#(
   parameter int OPW = 6,
   parameter int RCW = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           halt,
   output logic           imem_req,
   input  logic           imem_ack,
   input  logic [OPW-1:0] opcode,
   output logic           dmem_req,
   output logic           dmem_we,
   input  logic           dmem_ack,
   output logic           alu_start,
   input  logic           alu_done,
   input  logic [3:0]     flags,
   output logic           ir_load,
   output logic           ctrl_valid,
   output logic [7:0]     ctrl,
   output logic           pc_inc,
   output logic           pc_load,
   output logic           illegal,
   output logic           busy,
   output logic [RCW-1:0] retired
);

   state_t         state, state_nxt;
   logic [OPW-1:0] ir;
   iclass_t        icls;
   logic [7:0]     dec_ctrl;
   logic           taken;

   ctrl_decode #(.OPW(OPW)) u_decode (
      .ir   (ir),
      .icls (icls),
      .ctrl (dec_ctrl)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         ir      <= '0;
         retired <= '0;
         illegal <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_FETCH && imem_ack)
            ir <= opcode;
         if (state == ST_WB)
            retired <= retired + RCW'(1);
         if (state == ST_DECODE && icls == IC_ILLEGAL)
            illegal <= 1'b1;
      end
   end

   // Conditional branches 0..3 test z,n,c,o, which sit at flags[0..3] in the same order.
   assign taken = (icls == IC_JUMP) || (icls == IC_BRANCH && flags[ir[1:0]]);
   assign busy  = (state != ST_IDLE) && (state != ST_TRAP);

   always_comb begin
      state_nxt  = state;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      alu_start  = 1'b0;
      ir_load    = 1'b0;
      ctrl_valid = 1'b0;
      ctrl       = 8'h00;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !halt)
               state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_load   = 1'b1;
               state_nxt = ST_DECODE;
            end
         end
         ST_DECODE: begin
            case (icls)
               IC_MEM:     state_nxt = ST_MEM;
               IC_ILLEGAL: state_nxt = ST_TRAP;
`ifdef SEQ_MULTICYCLE_EN
               IC_MULTI: begin
                  alu_start = 1'b1;
                  state_nxt = ST_MULTI;
               end
`endif
               default:    state_nxt = ST_WB;
            endcase
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (ir == OPW'(OP_ST));
            if (dmem_ack)
               state_nxt = ST_WB;
         end
         // Only reachable when the multi-cycle ALU is enabled.
         ST_MULTI: begin
            if (alu_done)
               state_nxt = ST_WB;
         end
         ST_WB: begin
            ctrl_valid = 1'b1;
            ctrl       = dec_ctrl;
            pc_load    = taken;
            pc_inc     = !taken;
            state_nxt  = halt ? ST_IDLE : ST_FETCH;
         end
         ST_TRAP: state_nxt = ST_TRAP;
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
